// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/funct encodings, ALU select enum and NOP word for single_cycle_cpu
package cpu_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [31:0] NOP = 32'h00000013;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_e;
endpackage

// File: rtl/single_cycle_cpu_alu.sv
// cpu_alu: 64-bit add/sub/and/or with zero flag
import cpu_pkg::*;
module cpu_alu (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  alu_op_e     op,
  output logic [63:0] result,
  output logic        zero
);
  always_comb begin
    result = op == ALU_SUB ? a - b :
             op == ALU_AND ? a & b :
             op == ALU_OR  ? a | b : a + b;
    zero = result == 64'd0;
  end
endmodule

// File: rtl/single_cycle_cpu.sv
// single_cycle_cpu: RV64I subset core (add/sub/and/or/addi/ld/sd/beq) with fixed ROM
import cpu_pkg::*;
module single_cycle_cpu #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] debug_out
);
  localparam int DW = $clog2(DMEM_WORDS);
  logic [63:0] pc, pc_next, imm, rs1_v, rs2_v, alu_b, alu_res, wb;
  logic [63:0] regs [32];
  logic [63:0] dmem [DMEM_WORDS];
  logic [31:0] inst;
  logic [DW-1:0] idx;
  logic reg_we, mem_we, is_load, is_branch, use_imm, zero;
  alu_op_e alu_op;

  function automatic logic [31:0] rom(input logic [5:0] a);
    case (a)
      6'd0:  rom = 32'h00500093;
      6'd1:  rom = 32'h00A00113;
      6'd2:  rom = 32'h002081B3;
      6'd3:  rom = 32'h40110233;
      6'd4:  rom = 32'h00303023;
      6'd5:  rom = 32'h00003283;
      6'd6:  rom = 32'h00120463;
      6'd7:  rom = 32'h06300293;
      6'd8:  rom = 32'h0020F333;
      6'd9:  rom = 32'h0020E3B3;
      6'd10: rom = 32'h00728533;
      6'd11: rom = 32'h00000063;
      default: rom = NOP;
    endcase
  endfunction

  always_comb begin
    inst = pc < 64'(IMEM_WORDS * 4) ? rom(pc[7:2]) : NOP;
    rs1_v = regs[inst[19:15]];
    rs2_v = regs[inst[24:20]];
    reg_we = 1'b0;
    mem_we = 1'b0;
    is_load = 1'b0;
    is_branch = 1'b0;
    use_imm = 1'b0;
    alu_op = ALU_ADD;
    imm = {{52{inst[31]}}, inst[31:20]};
    case (inst[6:0])
      OP_R: begin
        if (inst[14:12] == F3_ADD && inst[31:25] == F7_ADD) reg_we = 1'b1;
        else if (inst[14:12] == F3_ADD && inst[31:25] == F7_SUB) begin
          reg_we = 1'b1;
          alu_op = ALU_SUB;
        end else if (inst[14:12] == F3_AND) begin
          reg_we = 1'b1;
          alu_op = ALU_AND;
        end else if (inst[14:12] == F3_OR) begin
          reg_we = 1'b1;
          alu_op = ALU_OR;
        end
      end
      OP_IMM: if (inst[14:12] == F3_ADD) {reg_we, use_imm} = 2'b11;
      OP_LOAD: if (inst[14:12] == F3_D) {reg_we, use_imm, is_load} = 3'b111;
      OP_STORE: if (inst[14:12] == F3_D) begin
        {mem_we, use_imm} = 2'b11;
        imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BRANCH: if (inst[14:12] == F3_BEQ) begin
        is_branch = 1'b1;
        alu_op = ALU_SUB;
        imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      default: ;
    endcase
    alu_b = use_imm ? imm : rs2_v;
  end

  cpu_alu alu (.a(rs1_v), .b(alu_b), .op(alu_op), .result(alu_res), .zero(zero));

  // Doubleword index ignores the low 3 bits (misalignment) and high bits (wrap)
  assign idx = alu_res[DW+2:3];
  assign wb = is_load ? dmem[idx] : alu_res;
  assign pc_next = is_branch && zero ? pc + imm : pc + 64'd4;
  assign debug_out = regs[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
    end else begin
      pc <= pc_next;
      if (reg_we && inst[11:7] != 5'd0) regs[inst[11:7]] <= wb;
      if (mem_we) dmem[idx] <= rs2_v;
    end
  end
endmodule

// File: tb/tb_single_cycle_cpu.sv
// tb_single_cycle_cpu: directed program-trace checks of the built-in ROM program
module tb_single_cycle_cpu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] debug_out;
  int tests = 0;
  int fails = 0;

  single_cycle_cpu dut (.clk(clk), .rst(rst), .debug_out(debug_out));

  always #5 clk = ~clk;

  typedef struct {logic [63:0] pc; logic [63:0] a0;} trace_t;
  typedef struct {int r; logic [63:0] v;} reg_t;
  trace_t tv[13];
  reg_t rv[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    bit seen;
    // pc/a0 after n commit edges following reset release
    tv = '{'{64'd0, 64'd0}, '{64'd4, 64'd0}, '{64'd8, 64'd0}, '{64'd12, 64'd0},
           '{64'd16, 64'd0}, '{64'd20, 64'd0}, '{64'd24, 64'd0}, '{64'd32, 64'd0},
           '{64'd36, 64'd0}, '{64'd40, 64'd0}, '{64'd44, 64'd30}, '{64'd44, 64'd30},
           '{64'd44, 64'd30}};
    rv = '{'{0, 64'd0}, '{1, 64'd5}, '{2, 64'd10}, '{3, 64'd15}, '{4, 64'd5},
           '{5, 64'd15}, '{6, 64'd0}, '{7, 64'd15}, '{10, 64'd30}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_a0", debug_out, 64'd0);
    chk("reset_pc", dut.pc, 64'd0);
    repeat (3) @(negedge clk);
    chk("reset_hold_a0", debug_out, 64'd0);
    chk("reset_hold_pc", dut.pc, 64'd0);
    rst = 1'b0;
    for (int n = 0; n < 13; n++) begin
      chk($sformatf("trace_pc[%0d]", n), dut.pc, tv[n].pc);
      chk($sformatf("trace_a0[%0d]", n), debug_out, tv[n].a0);
      chk($sformatf("x5_not_99[%0d]", n), 64'(dut.regs[5] == 64'd99), 64'd0);
      @(negedge clk);
    end
    for (int i = 0; i < 9; i++) chk($sformatf("reg_x%0d", rv[i].r), dut.regs[rv[i].r], rv[i].v);
    chk("mem0", dut.dmem[0], 64'd15);
    chk("mem1_untouched", dut.dmem[1], 64'd0);
    repeat (35) @(negedge clk);
    chk("halt_pc", dut.pc, 64'd44);
    chk("halt_a0", debug_out, 64'd30);
    for (int i = 0; i < 9; i++) chk($sformatf("halt_x%0d", rv[i].r), dut.regs[rv[i].r], rv[i].v);
    chk("halt_mem0", dut.dmem[0], 64'd15);
    // Restart from scratch, interrupt mid-program with a one-edge reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_pc_before", dut.pc, 64'd36);
    chk("mid_x3_before", dut.regs[3], 64'd15);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_pc", dut.pc, 64'd0);
    chk("mid_a0", debug_out, 64'd0);
    for (int i = 1; i < 8; i++) chk($sformatf("mid_x%0d", i), dut.regs[i], 64'd0);
    chk("mid_mem0", dut.dmem[0], 64'd0);
    seen = 1'b0;
    for (int n = 0; n < 12 && !seen; n++) begin
      @(negedge clk);
      seen = debug_out == 64'd30;
    end
    chk("mid_rerun_a0_within_12", 64'(seen), 64'd1);
    chk("x0_zero", dut.regs[0], 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
